// File: rtl/sr_latch_seq_pkg.sv
// rtl/sr_latch_seq_pkg.sv - shared state encoding and timing defaults for sr_latch_seq
package sr_latch_seq_pkg;

  localparam int DEF_PULSE_CYC  = 2;
  localparam int DEF_SETTLE_CYC = 1;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4
  } seq_state_e;

  // Timer holds (duration - 1), so the widest duration sets the counter width.
  function automatic int cyc_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sr_seq_timer.sv
// rtl/sr_seq_timer.sv - loadable down-counter with zero flag for INIT/PULSE/SETTLE durations
module sr_seq_timer #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_latch_seq.sv
// rtl/sr_latch_seq.sv - write sequencer for a NAND SR latch bank; SR_SEQ_VERIFY_EN adds readback check
module sr_latch_seq
  import sr_latch_seq_pkg::*;
#(
  parameter int N_LATCH    = 8,
  parameter int ADDR_W     = 3,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_data,
  output logic [N_LATCH-1:0] s_bar,
  output logic [N_LATCH-1:0] r_bar,
  input  logic [N_LATCH-1:0] q_in,
  output logic               done,
  output logic               err
);

  localparam int                 TMR_W = cyc_w(PULSE_CYC, SETTLE_CYC);
  localparam logic [TMR_W-1:0]   PULSE_LD  = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0]   SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [ADDR_W:0]    N_LIM = N_LATCH[ADDR_W:0];
  localparam logic [N_LATCH-1:0] ONE   = {{(N_LATCH-1){1'b0}}, 1'b1};

  seq_state_e          state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                data_q, data_d;
  logic                ok_q, ok_d;
  logic                err_d, done_d, ready_d;
  logic [N_LATCH-1:0]  s_bar_d, r_bar_d, sel_d;
  logic                tmr_load, tmr_zero;
  logic [TMR_W-1:0]    tmr_val;
  logic                req_in_range;

  // The timer comes out of reset already loaded with the INIT duration.
  sr_seq_timer #(
    .W       (TMR_W),
    .RST_VAL (PULSE_LD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign req_in_range = ({1'b0, req_addr} < N_LIM);

`ifdef SR_SEQ_VERIFY_EN
  logic [N_LATCH-1:0] sel_q;
  logic               q_bit;
  assign sel_q = ok_q ? (ONE << addr_q) : '0;
  assign q_bit = |(q_in & sel_q);
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
`endif

  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    data_d   = data_q;
    ok_d     = ok_q;
    err_d    = err;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_INIT: begin
        if (tmr_zero) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d   = req_addr;
          data_d   = req_data;
          ok_d     = req_in_range;
          err_d    = err | ~req_in_range;
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
`ifdef SR_SEQ_VERIFY_EN
          state_d = ST_CHECK;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef SR_SEQ_VERIFY_EN
      ST_CHECK: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (ok_q && (q_bit != data_q)) err_d = 1'b1;
      end
`endif
      default: state_d = ST_INIT;
    endcase

    // Bars are decoded from the next state so they register in step with it.
    sel_d   = ok_d ? (ONE << addr_d) : '0;
    s_bar_d = '1;
    r_bar_d = '1;
    if (state_d == ST_INIT) begin
      r_bar_d = '0;
    end else if (state_d == ST_PULSE) begin
      if (data_d) s_bar_d = ~sel_d;
      else        r_bar_d = ~sel_d;
    end
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      addr_q    <= '0;
      data_q    <= 1'b0;
      ok_q      <= 1'b0;
      s_bar     <= '1;
      r_bar     <= '0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ok_q      <= ok_d;
      s_bar     <= s_bar_d;
      r_bar     <= r_bar_d;
      req_ready <= ready_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_sr_latch_seq.sv
// tb/tb_sr_latch_seq.sv - scoreboard bench for sr_latch_seq with a behavioural NAND latch bank
module tb_sr_latch_seq;

  localparam int N  = 8;
  localparam int AW = 4;
  localparam int P  = 2;
  localparam int S  = 1;
`ifdef SR_SEQ_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif
  localparam int LAT = P + S + 1 + V;

  typedef struct {
    int           acc_cyc;
    logic [N-1:0] bank;
    logic         err;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_data = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready, done, err;
  logic [N-1:0]  s_bar, r_bar, q_in;
  logic [N-1:0]  q_bank = 8'hA5;
  logic [N-1:0]  force_mask = '0;
  logic [N-1:0]  bank_exp = '0;
  logic          err_model = 1'b0;
  bit            in_op = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            n_forbid = 0;
  int            n_multi = 0;
  txn_t          sb[$];

  sr_latch_seq #(
    .N_LATCH    (N),
    .ADDR_W     (AW),
    .PULSE_CYC  (P),
    .SETTLE_CYC (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .s_bar     (s_bar),
    .r_bar     (r_bar),
    .q_in      (q_in),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cross-coupled NAND pair per bit; both-low is counted separately as forbidden.
  always @(s_bar or r_bar) begin
    for (int i = 0; i < N; i++) begin
      if (!s_bar[i] && r_bar[i])      q_bank[i] = 1'b1;
      else if (s_bar[i] && !r_bar[i]) q_bank[i] = 1'b0;
    end
  end
  assign q_in = q_bank & ~force_mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic score_done();
    txn_t t;
    if (sb.size() == 0) begin
      chk("done_unexpected", 32'(done), 32'd0);
    end else begin
      t = sb.pop_front();
      chk("done_latency", cyc - t.acc_cyc, LAT);
      chk("q_bank", 32'(q_bank), 32'(t.bank));
      chk("err", 32'(err), 32'(t.err));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ((~s_bar & ~r_bar) != '0)) n_forbid <= n_forbid + 1;
    if (in_op && ($countones(~s_bar) + $countones(~r_bar) > 1)) n_multi <= n_multi + 1;
    if (rst_n && done === 1'b1) score_done();
  end

  task automatic do_req(input logic [AW-1:0] a, input logic d, input logic [N-1:0] fm);
    txn_t         t;
    logic [N-1:0] oh, es, er;
    bit           got;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_addr   = a;
    req_data   = d;
    force_mask = fm;
    oh = {{(N-1){1'b0}}, 1'b1} << a;
    bank_exp = d ? (bank_exp | oh) : (bank_exp & ~oh);
    if (oh == '0) err_model = 1'b1;
`ifdef SR_SEQ_VERIFY_EN
    if (oh != '0 && (((bank_exp & ~fm & oh) != '0) != d)) err_model = 1'b1;
`endif
    t.acc_cyc = cyc;
    t.bank    = bank_exp;
    t.err     = err_model;
    sb.push_back(t);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= P + S + V; k++) begin
      if (k > 1) @(negedge clk);
      es = '1;
      er = '1;
      if (k <= P) begin
        if (d) es = ~oh;
        else   er = ~oh;
      end
      chk(k <= P ? "s_bar_pulse" : "s_bar_settle", 32'(s_bar), 32'(es));
      chk(k <= P ? "r_bar_pulse" : "r_bar_settle", 32'(r_bar), 32'(er));
      chk("ready_busy", 32'(req_ready), 32'd0);
    end
  endtask

  task automatic reset_seq();
    rst_n = 1'b0;
    in_op = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_r_bar", 32'(r_bar), 32'h00);
    chk("rst_s_bar", 32'(s_bar), 32'hFF);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_r_bar", 32'(r_bar), 32'h00);
    @(negedge clk);
    chk("idle_r_bar", 32'(r_bar), 32'hFF);
    chk("idle_s_bar", 32'(s_bar), 32'hFF);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_q_bank", 32'(q_bank), 32'h00);
    chk("idle_err", 32'(err), 32'd0);
    err_model = 1'b0;
    bank_exp  = '0;
    in_op     = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic          rd;
    bit            got;

    reset_seq();

    do_req(4'd5, 1'b1, 8'h00);
    do_req(4'd3, 1'b1, 8'h00);
    do_req(4'd3, 1'b0, 8'h00);
    do_req(4'd5, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      ra = AW'($urandom_range(0, N - 1));
      rd = 1'($urandom_range(0, 1));
      do_req(ra, rd, 8'h00);
    end

    do_req(4'd2, 1'b1, 8'h04);
    do_req(4'd9, 1'b0, 8'h00);
    do_req(4'd15, 1'b1, 8'h00);
    do_req(4'd1, 1'b1, 8'h00);
    repeat (2) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);

    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("abort_ready", 32'(got), 32'd1);
    req_valid = 1'b1;
    req_addr  = 4'd6;
    req_data  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    in_op = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_s_bar", 32'(s_bar), 32'hFF);
    chk("abort_r_bar", 32'(r_bar), 32'h00);
    chk("abort_ready0", 32'(req_ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    reset_seq();

    do_req(4'd7, 1'b1, 8'h00);
    repeat (LAT + 2) @(negedge clk);

    chk("sb_drained", sb.size(), 32'd0);
    chk("forbidden_input", n_forbid, 32'd0);
    chk("multi_low", n_multi, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
